// File: rtl/divisor_ruta_datos_pkg.sv
// Shared definitions for the restoring-divider datapath: state-bit indices
// of the one-hot controller word and a multi-hot detector.
package divisor_ruta_datos_pkg;

  localparam int unsigned EST_W = 8;

  // Bit positions inside Est; the microcode assembler uses the same indices.
  typedef enum int unsigned {
    EST_REPOSO = 0,
    EST_CARGA  = 1,
    EST_VERIF  = 2,
    EST_DESPL  = 3,
    EST_RESTA  = 4,
    EST_AJUSTE = 5,
    EST_DECR   = 6,
    EST_FIN    = 7
  } estBit_e;

  // True when more than one state bit is asserted.
  function automatic logic esMultiHot(input logic [EST_W-1:0] e);
    return (e & (e - EST_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/divisor_ruta_datos_sumres.sv
// Shared adder/subtractor used by RESTA (subtract) and AJUSTE (restore add).
module divisor_sumres #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         resta,
  output logic [W-1:0] y
);

  // resta=1 computes a-b, otherwise a+b; both modulo 2^W.
  always_comb begin
    y = a + b;
    if (resta) y = a - b;
  end

endmodule

// File: rtl/divisor_ruta_datos.sv
// Restoring-divider datapath driven by the one-hot state word of the
// microprogrammed controller; returns the two branch flags it tests.
module divisor_ruta_datos
  import divisor_ruta_datos_pkg::*;
#(
  parameter int unsigned ANCHO  = 16,
  parameter int unsigned CONT_W = $clog2(ANCHO) + 1
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic [7:0]       Est,
  input  logic [ANCHO-1:0] dividendo_in,
  input  logic [ANCHO-1:0] divisor_in,
  output logic             Cont16NoCero,
  output logic             divisorNoCero,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] residuo,
  output logic             listo,
  output logic             error_div,
  output logic             error_est
);

  logic [ANCHO:0]   A;
  logic [ANCHO-1:0] Q;
  logic [ANCHO-1:0] M;
  logic [CONT_W-1:0] cnt;
  logic [ANCHO:0]   sumresY;
  logic             multiHot;

  assign multiHot      = esMultiHot(Est);
  assign Cont16NoCero  = (cnt != '0);
  assign divisorNoCero = (M != '0);

  // Subtract during RESTA, add back during AJUSTE; operand M is zero-extended.
  divisor_sumres #(.W(ANCHO + 1)) uSumres (
    .a     (A),
    .b     ({1'b0, M}),
    .resta (Est[EST_RESTA]),
    .y     (sumresY)
  );

  // One register transfer per asserted state bit; multi-hot words only flag an error.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      A         <= '0;
      Q         <= '0;
      M         <= '0;
      cnt       <= '0;
      cociente  <= '0;
      residuo   <= '0;
      listo     <= 1'b0;
      error_div <= 1'b0;
      error_est <= 1'b0;
    end else if (multiHot) begin
      error_est <= 1'b1;
    end else begin
      if (Est[EST_CARGA]) begin
        A         <= '0;
        Q         <= dividendo_in;
        M         <= divisor_in;
        cnt       <= CONT_W'(ANCHO);
        listo     <= 1'b0;
        error_div <= 1'b0;
        error_est <= 1'b0;
      end
      if (Est[EST_VERIF]) begin
        error_div <= (M == '0);
      end
      if (Est[EST_DESPL]) begin
        A <= {A[ANCHO-1:0], Q[ANCHO-1]};
        Q <= {Q[ANCHO-2:0], 1'b0};
      end
      if (Est[EST_RESTA]) begin
        A <= sumresY;
      end
      if (Est[EST_AJUSTE]) begin
        if (A[ANCHO]) begin
          A    <= sumresY;
          Q[0] <= 1'b0;
        end else begin
          Q[0] <= 1'b1;
        end
      end
      if (Est[EST_DECR]) begin
        if (cnt != '0) cnt <= cnt - CONT_W'(1);
      end
      if (Est[EST_FIN]) begin
        listo <= 1'b1;
        if (error_div) begin
          // The controller skipped the loop, so Q still holds the dividend.
          cociente <= '1;
          residuo  <= Q;
        end else begin
          cociente <= Q;
          residuo  <= A[ANCHO-1:0];
        end
      end
    end
  end

endmodule
